// File: rtl/arb_pkg.sv
// Shared definitions for the 8-requester arbiter.
// Holds the requester/index widths, hold-counter width, FSM state encoding
// and the index-to-one-hot helper used to build the grant vector.
package arb_pkg;

   localparam int unsigned N            = 8;
   localparam int unsigned IDW          = 3;
   localparam int unsigned CNTW         = 5;
   localparam int unsigned MAX_HOLD_DEF = 16;

   // State codes kept as plain constants so legacy code can compare against them.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      GRANT = ST_GRANT,
      GAP   = ST_GAP
   } arb_state_e;

   // Convert an encoded requester index into a one-hot grant vector.
   function automatic logic [N-1:0] onehot_from_idx(input logic [IDW-1:0] idx);
      return N'(1) << idx;
   endfunction

endpackage

// File: rtl/arb_pri_enc8.sv
// Combinational 8-to-3 priority encoder; the highest set bit wins.
// Ports:
//   vec_i   [7:0]  input vector
//   idx_o   [2:0]  index of highest set bit (0 when vec_i is zero)
//   valid_o        high when any bit of vec_i is set
module arb_pri_enc8
   import arb_pkg::*;
(
   input  logic [N-1:0]   vec_i,
   output logic [IDW-1:0] idx_o,
   output logic           valid_o
);

   // Ascending scan so the last (highest) set bit overrides earlier ones.
   always_comb begin
      idx_o = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (vec_i[i]) idx_o = IDW'(i);
      end
   end

   assign valid_o = |vec_i;

endmodule

// File: rtl/req_arbiter_8.sv
// Eight-requester arbiter with grant hold, hold-timeout revocation and a
// one-shot mask that lets the next requester in after a timeout.
// Optional feature: define ARB_ROUND_ROBIN_EN for rotating priority;
// default build is fixed priority with bit 7 highest.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        [7:0] level requests
//   gnt        [7:0] registered one-hot grant
//   gnt_id     [2:0] registered index of the granted requester (hold last)
//   gnt_valid  registered, high while gnt is non-zero
//   timeout    registered one-cycle pulse when the hold limit revokes a grant
module req_arbiter_8
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
)(
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_valid,
   output logic           timeout
);

   arb_state_e      state_q, state_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [IDW-1:0]  gnt_id_q, gnt_id_d;
   logic            gnt_valid_q, gnt_valid_d;
   logic            timeout_q, timeout_d;
   logic [CNTW-1:0] hold_cnt_q, hold_cnt_d;
   logic [N-1:0]    mask_q, mask_d;

   logic [N-1:0]    masked;
   logic [N-1:0]    eff;
   logic [N-1:0]    enc_in;
   logic [IDW-1:0]  enc_idx;
   logic            enc_valid;
   logic [IDW-1:0]  win_idx;
   logic            arb_go;

   // A masked requester that is the only one asking still gets served.
   assign masked = req & ~mask_q;
   assign eff    = (|masked) ? masked : req;

   arb_pri_enc8 u_enc (
      .vec_i   (enc_in),
      .idx_o   (enc_idx),
      .valid_o (enc_valid)
   );

   assign arb_go = ((state_q == IDLE) || (state_q == GAP)) && enc_valid;

`ifdef ARB_ROUND_ROBIN_EN
   logic [IDW-1:0] rr_q, rr_d;
   logic [IDW-1:0] shift;

   // Rotate so the pointer position lands on bit 7 (top priority of the encoder).
   assign shift = rr_q + IDW'(1);

   always_comb begin
      enc_in = '0;
      for (int j = 0; j < int'(N); j++) begin
         enc_in[j] = eff[IDW'(j) + shift];
      end
   end

   assign win_idx = enc_idx + shift;

   // Winner becomes lowest priority at the next arbitration.
   always_comb begin
      rr_d = rr_q;
      if (arb_go) rr_d = win_idx - IDW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_q <= IDW'(N - 1);
      else     rr_q <= rr_d;
   end
`else
   assign enc_in  = eff;
   assign win_idx = enc_idx;
`endif

   // Next-state and output decode.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      hold_cnt_d  = hold_cnt_q;
      mask_d      = mask_q;

      case (state_q)
         IDLE, GAP: begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
            state_d     = IDLE;
            if (arb_go) begin
               gnt_d       = onehot_from_idx(win_idx);
               gnt_id_d    = win_idx;
               gnt_valid_d = 1'b1;
               hold_cnt_d  = CNTW'(1);
               mask_d      = '0;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            // Release takes precedence over a coincident timeout.
            if (!req[gnt_id_q]) begin
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               hold_cnt_d  = '0;
               state_d     = GAP;
            end else if (hold_cnt_q == CNTW'(MAX_HOLD)) begin
               gnt_d            = '0;
               gnt_valid_d      = 1'b0;
               hold_cnt_d       = '0;
               timeout_d        = 1'b1;
               mask_d[gnt_id_q] = 1'b1;
               state_d          = GAP;
            end else begin
               hold_cnt_d = hold_cnt_q + CNTW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         hold_cnt_q  <= '0;
         mask_q      <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         hold_cnt_q  <= hold_cnt_d;
         mask_q      <= mask_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule
